i2c_master: RTL and testbench

Byte-oriented I2C bus master that sequences complete single-byte transactions: START, 7-bit address + R/W, one data byte written or read, ACK handling, STOP. It sits between a system-clocked requester and the open-drain SDA/SCL wires, and is the bus-side controller for the team's I2C slave blocks. One request is accepted at a time. There is no clock stretching and no multi-master arbitration.

---
 rtl/i2c_master.sv | 143 ++++++++++++++
 tb/tb_i2c_master.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master.sv
// i2c_master: single-byte I2C master (START, addr+R/W, one data byte, STOP).
// Open-drain SCL/SDA, no clock stretching, no multi-master arbitration.
module i2c_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rdata,
    output wire        scl,
    inout  wire        sda
);
    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, WRITE,
        WRITE_ACK, READ, READ_ACK, STOP
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] tick;
    logic [1:0]    phase;
    logic [2:0]    bit_cnt;
    logic [7:0]    addr_q;
    logic [7:0]    wdata_q;
    logic [6:0]    rx_sr;
    logic          smp_q;
    logic          scl_low, sda_low;
    logic          slot_end, sample, sda_in, bit_in, last_bit;

    assign sda_in   = sda;
    assign slot_end = (tick == TICK_MAX) && (phase == 2'd3);
    assign sample   = (tick == '0) && (phase == 2'd3);
    // With CLK_DIV=1 the sample and the slot end share a cycle.
    assign bit_in   = sample ? sda_in : smp_q;
    assign last_bit = (bit_cnt == 3'd7);
    assign busy     = (state != IDLE);
    assign scl      = scl_low ? 1'b0 : 1'bz;
    assign sda      = sda_low ? 1'b0 : 1'bz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tick    <= '0;
            phase   <= '0;
            bit_cnt <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rx_sr   <= '0;
            smp_q   <= 1'b0;
            done    <= 1'b0;
            ack_err <= 1'b0;
            rdata   <= '0;
        end else begin
            state <= state_n;
            done  <= (state == STOP) && slot_end;
            if (state == IDLE) begin
                tick    <= '0;
                phase   <= '0;
                bit_cnt <= '0;
                if (start) begin
                    addr_q  <= {addr, rw};
                    wdata_q <= wdata;
                    ack_err <= 1'b0;
                end
            end else begin
                if (tick == TICK_MAX) begin
                    tick  <= '0;
                    phase <= phase + 2'd1;
                end else begin
                    tick <= tick + TW'(1);
                end
                if (slot_end && (state == ADDR || state == WRITE || state == READ))
                    bit_cnt <= bit_cnt + 3'd1;
                if (sample) begin
                    smp_q <= sda_in;
                    if ((state == ADDR_ACK || state == WRITE_ACK) && sda_in)
                        ack_err <= 1'b1;
                    if (state == READ) begin
                        rx_sr <= {rx_sr[5:0], sda_in};
                        if (last_bit)
                            rdata <= {rx_sr, sda_in};
                    end
                end
            end
        end
    end

    always_comb begin
        state_n = state;
        scl_low = 1'b0;
        sda_low = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_n = START;
            end
            START: begin
                sda_low = phase[1];
                if (slot_end) state_n = ADDR;
            end
            ADDR: begin
                scl_low = ~phase[1];
                sda_low = ~addr_q[~bit_cnt];
                if (slot_end && last_bit) state_n = ADDR_ACK;
            end
            ADDR_ACK: begin
                scl_low = ~phase[1];
                if (slot_end)
                    state_n = bit_in ? STOP : (addr_q[0] ? READ : WRITE);
            end
            WRITE: begin
                scl_low = ~phase[1];
                sda_low = ~wdata_q[~bit_cnt];
                if (slot_end && last_bit) state_n = WRITE_ACK;
            end
            WRITE_ACK: begin
                scl_low = ~phase[1];
                if (slot_end) state_n = STOP;
            end
            READ: begin
                scl_low = ~phase[1];
                if (slot_end && last_bit) state_n = READ_ACK;
            end
            READ_ACK: begin
                scl_low = ~phase[1];
                if (slot_end) state_n = STOP;
            end
            STOP: begin
                scl_low = ~phase[1];
                sda_low = (phase != 2'd3);
                if (slot_end) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: scoreboard bench with a behavioural I2C slave and bus monitor.
// Expected results come from a transaction-level model of the byte exchange.
module tb_i2c_master;
    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] addr = '0;
    logic [7:0] wdata = '0;
    logic       busy, done, ack_err;
    logic [7:0] rdata;
    wire        scl, sda;
    logic       slv_low = 1'b0;

    pullup (scl);
    pullup (sda);
    assign sda = slv_low ? 1'b0 : 1'bz;

    i2c_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst(rst), .start(start), .addr(addr), .rw(rw),
        .wdata(wdata), .busy(busy), .done(done), .ack_err(ack_err),
        .rdata(rdata), .scl(scl), .sda(sda)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // slave configuration
    logic [6:0] slv_addr = 7'h77;
    logic [7:0] slv_rbyte = 8'h00;
    bit         slv_dack = 1'b1;

    typedef struct {
        logic [17:0] bits;
        int          nbits;
        logic        ack_err;
        logic [7:0]  rdata;
        int          lat;
        int unsigned acc;
    } item_t;
    item_t sb[$];
    logic [7:0] m_rdata = 8'h00;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Transaction-level model: which bits appear on the bus and the outcome.
    function automatic item_t model(input logic r, input logic [6:0] a,
                                    input logic [7:0] d);
        item_t it;
        bit hit;
        hit = (a == slv_addr);
        it.nbits = hit ? 18 : 9;
        if (hit)
            it.bits = {a, r, 1'b0, (r ? slv_rbyte : d), (r ? 1'b1 : !slv_dack)};
        else
            it.bits = 18'({a, r, 1'b1});
        it.ack_err = !hit || (!r && !slv_dack);
        if (hit && r) m_rdata = slv_rbyte;
        it.rdata = m_rdata;
        it.lat = 4 * CLK_DIV * (it.nbits + 2);
        it.acc = 0;
        return it;
    endfunction

    task automatic push_exp(input logic r, input logic [6:0] a,
                            input logic [7:0] d);
        item_t it;
        it = model(r, a, d);
        it.acc = cyc + 1;
        sb.push_back(it);
    endtask

    // Bus monitor and slave, all sampled on the falling system clock.
    bit          p_scl = 1'b1, p_sda = 1'b1, in_tx = 1'b0, hit = 1'b0, rd = 1'b0;
    int          bitn = 0, bus_n = 0, starts = 0, stops = 0;
    logic [18:0] cap = '0;
    logic [17:0] bus_bits = '0;

    always @(negedge clk) begin
        bit sv, dv;
        sv = (scl !== 1'b0);
        dv = (sda !== 1'b0);
        if (rst) begin
            if (in_tx) starts--;
            in_tx = 1'b0;
            bitn = 0;
            slv_low = 1'b0;
            sv = 1'b1;
            dv = 1'b1;
        end else if (p_scl && sv && p_sda && !dv) begin
            chk("start_nested", in_tx, 0);
            in_tx = 1'b1;
            bitn = 0;
            cap = '0;
            starts++;
        end else if (p_scl && sv && !p_sda && dv) begin
            chk("stop_orphan", in_tx, 1);
            in_tx = 1'b0;
            stops++;
            // the STOP slot's own SCL rise is not a data bit
            bus_bits = cap[18:1];
            bus_n = bitn - 1;
        end else if (in_tx && !p_scl && sv) begin
            cap = {cap[17:0], dv};
            bitn++;
            if (bitn == 8) begin
                hit = (cap[7:1] == slv_addr);
                rd = cap[0];
            end
        end else if (in_tx && p_scl && !sv) begin
            if (bitn == 8)
                slv_low = hit;
            else if (bitn >= 9 && bitn <= 16)
                slv_low = hit && rd && !slv_rbyte[16 - bitn];
            else if (bitn == 17)
                slv_low = hit && !rd && slv_dack;
            else
                slv_low = 1'b0;
        end
        p_scl = sv;
        p_sda = dv;
    end

    // Scoreboard monitor: pops one expectation per done pulse.
    bit p_done = 1'b0;
    always @(negedge clk) begin
        item_t it;
        if (!rst) begin
            if (done) begin
                chk("done_busy", busy, 0);
                chk("done_double", p_done, 0);
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done got=1 exp=0 t=%0t", $time);
                end else begin
                    it = sb.pop_front();
                    chk("latency", cyc - it.acc, it.lat);
                    chk("ack_err", ack_err, it.ack_err);
                    chk("rdata", rdata, it.rdata);
                    chk("bus_bits", bus_bits, it.bits);
                    chk("bus_nbits", bus_n, it.nbits);
                    chk("start_stop_pair", starts, stops);
                end
            end
            p_done = done;
        end else begin
            p_done = 1'b0;
        end
    end

    task automatic issue(input logic r, input logic [6:0] a,
                         input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout got=1 exp=0 t=%0t", $time);
        end
        rw = r;
        addr = a;
        wdata = d;
        start = 1'b1;
        push_exp(r, a, d);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 5000);
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL done_timeout got=0 exp=1 t=%0t", $time);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ack_err", ack_err, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_scl", scl, 1);
        chk("rst_sda", sda, 1);
        rst = 1'b0;

        issue(1'b0, 7'h77, 8'h5A);
        wait_done();
        slv_rbyte = 8'hAA;
        issue(1'b1, 7'h77, 8'h00);
        wait_done();
        issue(1'b0, 7'h12, 8'h33);
        wait_done();

        // asynchronous reset in the middle of the address byte
        issue(1'b0, 7'h77, 8'hC3);
        repeat (40) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_scl", scl, 1);
        chk("mid_rst_sda", sda, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rdata", rdata, 0);
        chk("mid_rst_ack_err", ack_err, 0);
        sb.delete();
        m_rdata = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        slv_rbyte = 8'h5C;
        issue(1'b1, 7'h77, 8'h00);
        wait_done();

        // start held through a busy transaction, re-accepted in the done cycle
        @(negedge clk);
        rw = 1'b0;
        addr = 7'h77;
        wdata = 8'h3C;
        start = 1'b1;
        push_exp(1'b0, 7'h77, 8'h3C);
        @(negedge clk);
        chk("b2b_busy_first", busy, 1);
        rw = 1'b1;
        wdata = 8'hFF;
        slv_rbyte = 8'h96;
        wait_done();
        push_exp(1'b1, 7'h77, 8'hFF);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("b2b_busy_second", busy, 1);
        wait_done();
        repeat (30) @(negedge clk);
        chk("b2b_no_third", busy, 0);

        for (int i = 0; i < 10; i++) begin
            logic       r;
            logic [6:0] a;
            r = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h77;
            slv_dack = ($urandom_range(0, 3) != 0);
            slv_rbyte = 8'($urandom);
            issue(r, a, 8'($urandom));
            wait_done();
        end

        repeat (50) @(negedge clk);
        chk("end_idle", busy, 0);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
